// File: rtl/fortaegis_pkg.sv
// Shared constants and FSM state type for the Fortaegis capture stage.
package fortaegis_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/fort_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module fort_capture_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write and 1-cycle-latency read; no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fort_sample_capture.sv
// Capture stage: records qualified samples while collect is high, then drains
// the window in order over a valid/ready stream with a last marker.
module fort_sample_capture
  import fortaegis_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk350,
  input  logic              rstn,
  input  logic              collect,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_vld,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              done
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              rd_pend_q, rd_pend_d;
  logic              out_v_q, out_v_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              pop, last;
  logic [1:0]        slots;

  fort_capture_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk  (clk350),
    .we   (ram_we),
    .waddr(count_q[PTR_W-1:0]),
    .wdata(sample_in),
    .re   (ram_re),
    .raddr(rd_cnt_q[PTR_W-1:0]),
    .rdata(ram_rdata)
  );

  // The word in the output register is always index pop_cnt of the window.
  assign last = out_v_q && (pop_cnt_q == count_q - CNT_W'(1));
  assign pop  = out_v_q && m_ready;

  // Next-state, counters, RAM control and output/skid stage.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_cnt_d    = rd_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    slots       = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, rd_pend_q};

    // Output register refills from skid first, then from the RAM read in flight;
    // a read returning while the output is stalled parks in the skid register.
    if (!out_v_q || pop) begin
      if (skid_v_q) begin
        out_v_d    = 1'b1;
        out_data_d = skid_data_q;
        skid_v_d   = rd_pend_q;
        if (rd_pend_q) skid_data_d = ram_rdata;
      end else if (rd_pend_q) begin
        out_v_d    = 1'b1;
        out_data_d = ram_rdata;
      end else begin
        out_v_d    = 1'b0;
      end
    end else if (rd_pend_q) begin
      skid_v_d    = 1'b1;
      skid_data_d = ram_rdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (collect) begin
          state_d   = ST_CAPTURE;
          count_d   = '0;
          rd_cnt_d  = '0;
          pop_cnt_d = '0;
          ovf_d     = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (sample_vld) begin
          if (count_q != FULL) begin
            ram_we  = 1'b1;
            count_d = count_q + CNT_W'(1);
          end else begin
            ovf_d   = 1'b1;
          end
        end
        // Full is judged on the registered count, so one extra capture cycle at
        // full can record a dropped sample before the drain starts.
        if (!collect || count_q == FULL) begin
          state_d = (count_d == '0) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Issue a read only if it will have a slot once it lands.
        if ((rd_cnt_q != count_q) && ((slots < 2'd2) || (pop && slots == 2'd2))) begin
          ram_re   = 1'b1;
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        if (pop) begin
          pop_cnt_d = pop_cnt_q + CNT_W'(1);
          if (last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_pend_d = ram_re;

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk350 or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rd_cnt_q    <= '0;
      pop_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_cnt_q    <= rd_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      rd_pend_q   <= rd_pend_d;
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign m_data   = out_data_q;
  assign m_valid  = out_v_q;
  assign m_last   = last;
  assign busy     = (state_q != ST_IDLE);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule
